// File: rtl/led_bin_display_pwm.sv
// -----------------------------------------------------------------------------
// led_bin_display_pwm
//
// Purpose:
//   Drives one LED per bit of a WIDTH-bit value that is captured on a load
//   strobe. A free-running PWM counter sets the LED brightness.
//   When a new value differs from the shown one, the changed bits blink for
//   BLINK_COUNT full periods. Each period is BLINK_DIV cycles dark, then
//   BLINK_DIV cycles lit. The unchanged bits stay steady.
//
// Optional feature:
//   LED_BIN_DISPLAY_GRAY_EN - when defined, bin_number is Gray code. It is
//   converted to binary before the compare and the capture, so value_q
//   always holds binary. When the macro is undefined, bin_number is
//   captured as plain binary.
//
// Ports:
//   clock       in   1         system clock, rising edge
//   reset       in   1         synchronous, active-high
//   bin_number  in   WIDTH     value to display
//   load        in   1         capture bin_number this cycle
//   brightness  in   PWM_BITS  duty: 0 = dark, all-ones = always on
//   leds        out  WIDTH     LED drive, bit i -> weight 2^i (registered)
//   busy        out  1         high while changed bits are blinking (registered)
// -----------------------------------------------------------------------------
module led_bin_display_pwm #(
    parameter int WIDTH       = 4,
    parameter int PWM_BITS    = 4,
    parameter int BLINK_DIV   = 25000000,
    parameter int BLINK_COUNT = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    bin_number,
    input  logic                load,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [WIDTH-1:0]    leds,
    output logic                busy
);

    localparam int BL_W = $clog2(2*BLINK_COUNT + 1);
    localparam int PR_W = $clog2(BLINK_DIV);
    localparam logic [BL_W-1:0] BL_INIT = BL_W'(2*BLINK_COUNT);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(BLINK_DIV - 1);

    typedef enum logic {SHOW, HILITE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    value_q;
    logic [WIDTH-1:0]    mask_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PR_W-1:0]     presc;
    logic                phase;
    logic [BL_W-1:0]     blink_left;

    // Binary form of the incoming word.
    logic [WIDTH-1:0]    bin_value;

`ifdef LED_BIN_DISPLAY_GRAY_EN
    // Binary bit i is the XOR of all Gray bits from the MSB down to bit i.
    // Each bit is a reduction of the input word, so no bit depends on
    // another bit of bin_value.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_gray
            assign bin_value[gi] = ^bin_number[WIDTH-1:gi];
        end
    endgenerate
`else
    assign bin_value = bin_number;
`endif

    logic             changed;
    logic             pwm_on;
    logic [WIDTH-1:0] disp;

    assign changed = load && (bin_value != value_q);

    // The all-ones brightness forces the LEDs on. A plain compare would
    // leave one dark slot in each PWM period.
    assign pwm_on  = (brightness == {PWM_BITS{1'b1}}) || (pwm_cnt < brightness);

    // Changed bits are dark in phase 0 and lit in phase 1.
    assign disp    = value_q & ~(mask_q & {WIDTH{~phase}});

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SHOW;
            value_q    <= '0;
            mask_q     <= '0;
            pwm_cnt    <= '0;
            presc      <= '0;
            phase      <= 1'b0;
            blink_left <= '0;
            leds       <= '0;
            busy       <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            leds    <= pwm_on ? disp : '0;

            if (changed) begin
                // Entering HILITE and restarting inside it do the same thing.
                // A new value takes priority over a tick in the same cycle.
                value_q    <= bin_value;
                mask_q     <= bin_value ^ value_q;
                blink_left <= BL_INIT;
                phase      <= 1'b0;
                presc      <= '0;
                state      <= HILITE;
                busy       <= 1'b1;
            end else if (state == HILITE) begin
                if (presc == PR_LAST) begin
                    presc      <= '0;
                    blink_left <= blink_left - 1'b1;
                    if (blink_left == BL_ONE) begin
                        state  <= SHOW;
                        mask_q <= '0;
                        phase  <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        phase  <= ~phase;
                        busy   <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                    busy  <= 1'b1;
                end
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_bin_display_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_bin_display_pwm
//
// Purpose:
//   Self-checking bench for led_bin_display_pwm. It uses WIDTH=4,
//   PWM_BITS=2, BLINK_DIV=4 and BLINK_COUNT=2, so one highlight lasts
//   16 cycles.
//
//   A timing model describes the highlight in terms of the time elapsed
//   since the last change:
//     - The phase is (elapsed / BLINK_DIV) mod 2.
//     - The highlight ends after 2*BLINK_COUNT*BLINK_DIV cycles.
//     - The PWM slot is the cycle count since reset, mod 2^PWM_BITS.
//   A compare process checks leds and busy against the model on every
//   cycle. Directed scenarios add literal checks at hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_led_bin_display_pwm;

    localparam int WIDTH       = 4;
    localparam int PWM_BITS    = 2;
    localparam int BLINK_DIV   = 4;
    localparam int BLINK_COUNT = 2;
    localparam int HILITE_LEN  = 2*BLINK_COUNT*BLINK_DIV;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [WIDTH-1:0]    bin_number = '0;
    logic                load = 1'b0;
    logic [PWM_BITS-1:0] brightness = 2'd3;
    logic [WIDTH-1:0]    leds;
    logic                busy;

    led_bin_display_pwm #(
        .WIDTH       (WIDTH),
        .PWM_BITS    (PWM_BITS),
        .BLINK_DIV   (BLINK_DIV),
        .BLINK_COUNT (BLINK_COUNT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bin_number (bin_number),
        .load       (load),
        .brightness (brightness),
        .leds       (leds),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Converts the word on the input pins to the binary value it stands for.
    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] b;
        b = raw;
`ifdef LED_BIN_DISPLAY_GRAY_EN
        for (int s = 1; s < WIDTH; s++) b = b ^ (raw >> s);
`endif
        return b;
    endfunction

    // Encodes an intended binary value for the input pins.
    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
`ifdef LED_BIN_DISPLAY_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_value, m_mask, m_leds;
    logic             m_busy, m_hilite;
    int               m_elapsed, m_cyc;
    bit               m_valid = 1'b0;

    always @(posedge clock) begin
        logic [WIDTH-1:0] nv, d;
        int               ph;
        bit               on;
        if (reset) begin
            m_value = '0; m_mask = '0; m_leds = '0;
            m_busy = 1'b0; m_hilite = 1'b0;
            m_elapsed = 0; m_cyc = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ph = m_hilite ? (m_elapsed / BLINK_DIV) % 2 : 1;
            d  = (ph == 0) ? (m_value & ~m_mask) : m_value;
            on = (brightness == 2'd3) || ((m_cyc % 4) < int'(brightness));
            m_leds = on ? d : '0;
            nv = to_bin(bin_number);
            if (load && nv != m_value) begin
                m_mask = nv ^ m_value;
                m_value = nv;
                m_hilite = 1'b1;
                m_elapsed = 0;
            end else if (m_hilite) begin
                m_elapsed++;
                if (m_elapsed == HILITE_LEN) begin
                    m_hilite = 1'b0;
                    m_mask = '0;
                end
            end
            m_cyc++;
            m_busy = m_hilite;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_leds", {28'd0, leds}, {28'd0, m_leds});
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] raw);
        bin_number = raw;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        $display("load bin_number=%b leds=%b busy=%b t=%0t", raw, leds, busy, $time);
    endtask

`ifdef LED_BIN_DISPLAY_GRAY_EN
    localparam logic [WIDTH-1:0] T6_EXP = 4'b1001;
`else
    localparam logic [WIDTH-1:0] T6_EXP = 4'b1101;
`endif

    initial begin
        int lit;
        // 1: reset, then first load with blink
        step(3);
        check("reset_leds", {28'd0, leds}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step(1);
        do_load(enc(4'b1010));
        check("t1_busy", {31'd0, busy}, 32'd1);
        step(2);
        check("t1_dark", {28'd0, leds}, 32'h0);
        step(4);
        check("t1_lit", {28'd0, leds}, 32'ha);
        step(14);
        check("t1_done_busy", {31'd0, busy}, 32'd0);
        check("t1_done_leds", {28'd0, leds}, 32'ha);

        // 2: equal load is ignored
        do_load(enc(4'b1010));
        check("t2_busy", {31'd0, busy}, 32'd0);
        step(2);
        check("t2_leds", {28'd0, leds}, 32'ha);

        // 3: restart mid-highlight
        do_load(enc(4'b0111));
        step(5);
        do_load(enc(4'b0001));
        check("t3_busy", {31'd0, busy}, 32'd1);
        step(15);
        check("t3_busy_last", {31'd0, busy}, 32'd1);
        step(1);
        check("t3_busy_end", {31'd0, busy}, 32'd0);
        step(4);
        check("t3_leds", {28'd0, leds}, 32'h1);

        // 4: PWM duty
        do_load(enc(4'b1111));
        step(20);
        check("t4_full", {28'd0, leds}, 32'hf);
        brightness = 2'd1;
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (leds == 4'b1111) lit++;
        end
        check("t4_duty1_count", lit, 32'd2);
        brightness = 2'd0;
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (leds != 4'b0000) lit++;
        end
        check("t4_duty0_count", lit, 32'd0);
        brightness = 2'd3;
        step(2);

        // 5: reset aborts highlight
        do_load(enc(4'b0000));
        step(5);
        reset = 1'b1;
        step(1);
        check("t5_leds", {28'd0, leds}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        step(2);
        reset = 1'b0;
        step(20);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        do_load(enc(4'b0100));
        check("t5_reload_busy", {31'd0, busy}, 32'd1);
        step(20);

        // 6: raw word 1101 on the input pins
        do_load(4'b1101);
        step(20);
        check("t6_leds", {28'd0, leds}, {28'd0, T6_EXP});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
